key_play_scheduler: RTL

Sequences note playback for the 15 white piano keys (L_5..H_5) drawn on the VGA keyboard bar. Arbitrates the 15 key-request lines round-robin into one active note and hands it to the tone generator with a valid/ready handshake. Enforces a minimum note duration and a release gap between notes. Drives a per-key highlight mask that updates only at frame start, so the key-bar renderer never tears mid-frame.

---
 rtl/synth_pkg.sv | 37 +++
 rtl/key_play_scheduler_rr_arbiter15.sv | 27 ++
 rtl/key_play_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared key map, FSM states and helpers for the key-bar synth
package synth_pkg;

  localparam int NUM_KEYS = 15;

  // Same index map the key-bar renderer and the tone table use
  localparam logic [3:0] KEY_L5 = 4'd0;
  localparam logic [3:0] KEY_L6 = 4'd1;
  localparam logic [3:0] KEY_L7 = 4'd2;
  localparam logic [3:0] KEY_M1 = 4'd3;
  localparam logic [3:0] KEY_M2 = 4'd4;
  localparam logic [3:0] KEY_M3 = 4'd5;
  localparam logic [3:0] KEY_M4 = 4'd6;
  localparam logic [3:0] KEY_M5 = 4'd7;
  localparam logic [3:0] KEY_M6 = 4'd8;
  localparam logic [3:0] KEY_M7 = 4'd9;
  localparam logic [3:0] KEY_H1 = 4'd10;
  localparam logic [3:0] KEY_H2 = 4'd11;
  localparam logic [3:0] KEY_H3 = 4'd12;
  localparam logic [3:0] KEY_H4 = 4'd13;
  localparam logic [3:0] KEY_H5 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_PLAY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] idx);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/key_play_scheduler_rr_arbiter15.sv
// rtl/key_play_scheduler_rr_arbiter15.sv - combinational round-robin pick over 15 key requests
module rr_arbiter15
  import synth_pkg::*;
(
  input  logic [NUM_KEYS-1:0] req,
  input  logic [3:0]          last,
  output logic [3:0]          gnt_idx,
  output logic                gnt_any
);

  logic [3:0] k;

  // Search starts one past the previous grant and wraps 14 -> 0
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    for (int i = 1; i <= NUM_KEYS; i++) begin
      k = 4'((32'(last) + 32'(i)) % NUM_KEYS);
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/key_play_scheduler.sv
// rtl/key_play_scheduler.sv - round-robin note sequencer with hold/release timing and frame-synced highlight
module key_play_scheduler
  import synth_pkg::*;
#(
  parameter int HOLD_TICKS    = 2500000,
  parameter int RELEASE_TICKS = 1250000,
  parameter int CNT_W         = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_req,
  input  logic                frame_start,
  output logic                note_valid,
  output logic [3:0]          note_idx,
  input  logic                note_ready,
  output logic                playing,
  output logic [NUM_KEYS-1:0] highlight
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_TICKS - 1);

  state_t              state, state_d;
  logic [3:0]          note_idx_d;
  logic [3:0]          last_grant, last_grant_d;
  logic [CNT_W-1:0]    counter, counter_d;
  logic [NUM_KEYS-1:0] shadow, shadow_d;
  logic [3:0]          gnt_idx;
  logic                gnt_any;

  rr_arbiter15 u_arb (
    .req     (key_req),
    .last    (last_grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      note_idx   <= '0;
      last_grant <= KEY_H5;
      counter    <= '0;
      shadow     <= '0;
      highlight  <= '0;
    end else begin
      state      <= state_d;
      note_idx   <= note_idx_d;
      last_grant <= last_grant_d;
      counter    <= counter_d;
      shadow     <= shadow_d;
      // Pre-edge shadow is used so a frame never sees a mid-transition mask
      if (frame_start) begin
        highlight <= shadow;
      end
    end
  end

  always_comb begin
    state_d      = state;
    note_idx_d   = note_idx;
    last_grant_d = last_grant;
    counter_d    = counter;
    case (state)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d      = ST_ISSUE;
          note_idx_d   = gnt_idx;
          last_grant_d = gnt_idx;
        end
      end
      ST_ISSUE: begin
        if (note_ready) begin
          state_d   = ST_PLAY;
          counter_d = '0;
        end
      end
      ST_PLAY: begin
        if (counter >= HOLD_LAST) begin
          if (!key_req[note_idx]) begin
            state_d   = ST_RELEASE;
            counter_d = '0;
          end
        end else begin
          counter_d = counter + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (counter == REL_LAST) begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end else begin
          counter_d = counter + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    shadow_d = ((state_d == ST_ISSUE) || (state_d == ST_PLAY)) ? key_onehot(note_idx_d) : '0;
  end

  assign note_valid = (state == ST_ISSUE);
  assign playing    = (state == ST_PLAY);

endmodule
